traffic_sensor_aggregator: RTL and testbench
============================================

TRAFFIC_SENSOR_AGGREGATOR -- requirements
Module: traffic_sensor_aggregator

Interface
REQ-001 SHALL have parameter ONE_SECOND, default 50: clock cycles per second.
REQ-002 SHALL have parameter WINDOW_SECONDS, default 10: prediction window length in seconds.
REQ-003 SHALL have parameter EMERG_HOLD_SECONDS, default 5: emergency clearance hold in seconds.
REQ-004 SHALL have parameters LVL_TH1/LVL_TH2/LVL_TH3, defaults 16/32/64: queue thresholds for congestion levels 1/2/3.
REQ-005 SHALL have port clk, input, 1: clock.
REQ-006 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port arrive, input, 4: one-cycle vehicle-arrival pulses; bit0 N, bit1 S, bit2 E, bit3 W.
REQ-008 SHALL have port depart, input, 4: one-cycle vehicle-departure pulses; same bit order.
REQ-009 SHALL have port emerg_req, input, 4: level emergency requests; same bit order.
REQ-010 SHALL have ports north_queue/south_queue/east_queue/west_queue, output, 8 each: vehicle count per direction.
REQ-011 SHALL have ports north_ml_level/south_ml_level/east_ml_level/west_ml_level, output, 2 each: congestion level per direction.
REQ-012 SHALL have port ml_prediction_valid, output, 1: one-cycle pulse when levels update.
REQ-013 SHALL have port emergency_override, output, 1: emergency active.
REQ-014 SHALL have port emergency_direction, output, 2: granted direction; 0 N, 1 S, 2 E, 3 W.

Function
REQ-015 SHALL update each queue per clock: arrival only +1, departure only -1, both or neither unchanged.
REQ-016 SHALL saturate queues: increment at 255 holds 255; decrement at 0 holds 0.
REQ-017 SHALL run a window counter 0..WINDOW_SECONDS*ONE_SECOND-1, wrapping to 0 at terminal count.
REQ-018 SHALL, on the edge where the window counter wraps, pulse ml_prediction_valid for exactly one cycle and update all four levels on that same edge.
REQ-019 SHALL compute each level from the queue value registered before that edge: <LVL_TH1 -> 0; <LVL_TH2 -> 1; <LVL_TH3 -> 2; else 3.
REQ-020 SHALL hold levels constant between valid pulses; the first pulse occurs WINDOW_SECONDS*ONE_SECOND cycles after reset release.
REQ-021 SHALL implement the emergency FSM with states IDLE, ACTIVE, HOLD.
REQ-022 IDLE: any emerg_req bit set -> grant lowest-index set bit, go ACTIVE. emergency_override=1 and emergency_direction=grant from the next cycle; direction is registered.
REQ-023 ACTIVE: stay while the granted bit is set; other bits are ignored (no preemption). Granted bit low -> HOLD, hold counter cleared.
REQ-024 HOLD: override and direction held. Granted bit reasserted -> ACTIVE. Otherwise, after EMERG_HOLD_SECONDS*ONE_SECOND cycles -> IDLE, override=0.
REQ-025 HOLD: requests from other directions are ignored. They are arbitrated in IDLE on the cycle after the IDLE entry.
REQ-026 SHALL keep emergency_direction at its last grant while in IDLE.
REQ-027 Queue counting and windowing SHALL continue unaffected during emergency states.

Reset
REQ-028 Reset asserted, even mid-operation, SHALL immediately force: queues 0, levels 0, ml_prediction_valid 0, window counter 0, FSM IDLE, hold counter 0, emergency_override 0, emergency_direction 0.
REQ-029 After reset deasserts, the first active edge SHALL process inputs normally.

Configuration
REQ-030 With EMERG_ARB_EN defined, the emergency FSM of REQ-021..026 SHALL be compiled in. Without it, emerg_req is ignored, emergency_override is constant 0 and emergency_direction is constant 0. Queue and level behaviour is identical in both builds.

Verification
REQ-031 Reset, then 20 north arrive pulses -> north_queue=20. 25 north depart pulses -> north_queue=0.
REQ-032 east_queue=255 plus one more arrive -> stays 255. arrive[1] and depart[1] in the same cycle with south_queue=7 -> stays 7.
REQ-033 ONE_SECOND=2, WINDOW_SECONDS=2, west_queue=40 -> valid pulse at cycle 4 after reset, one cycle wide, west_ml_level=2. Other levels 0 when their queues are 0.
REQ-034 EMERG_ARB_EN defined, emerg_req=4'b1100 -> next cycle override=1, direction=2. Then emerg_req=4'b1000 -> HOLD, direction stays 2. After hold expiry, override drops, then re-asserts next cycle with direction=3.
REQ-035 During HOLD, reassert the granted bit -> returns to ACTIVE, override never drops. Reset mid-ACTIVE -> override=0, all queues 0 immediately.

Source files
------------

// File: rtl/traffic_sensor_aggregator.sv
// Four-approach vehicle queue counter with windowed congestion levels and an
// optional emergency-priority arbiter (compiled in when EMERG_ARB_EN is defined).
module traffic_sensor_aggregator #(
  parameter int ONE_SECOND         = 50,
  parameter int WINDOW_SECONDS     = 10,
  parameter int EMERG_HOLD_SECONDS = 5,
  parameter int LVL_TH1            = 16,
  parameter int LVL_TH2            = 32,
  parameter int LVL_TH3            = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] arrive,
  input  logic [3:0] depart,
  input  logic [3:0] emerg_req,
  output logic [7:0] north_queue,
  output logic [7:0] south_queue,
  output logic [7:0] east_queue,
  output logic [7:0] west_queue,
  output logic [1:0] north_ml_level,
  output logic [1:0] south_ml_level,
  output logic [1:0] east_ml_level,
  output logic [1:0] west_ml_level,
  output logic       ml_prediction_valid,
  output logic       emergency_override,
  output logic [1:0] emergency_direction
);

  localparam int WIN_CYC = WINDOW_SECONDS * ONE_SECOND;
  localparam int WIN_W   = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;

  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] win_d;
  logic             win_wrap;
  logic             valid_q;
  logic [31:0]      queue_all;
  logic [7:0]       level_all;

  assign win_wrap = (win_q == WIN_W'(WIN_CYC - 1));
  assign win_d    = win_wrap ? '0 : win_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      win_q   <= win_d;
      valid_q <= win_wrap;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dir
      logic [7:0] queue_q;
      logic [7:0] queue_d;
      logic [1:0] level_q;
      logic [1:0] level_d;

      // Simultaneous arrive/depart cancels; both ends saturate.
      always_comb begin
        queue_d = queue_q;
        if (arrive[gi] && !depart[gi] && (queue_q != 8'hFF)) begin
          queue_d = queue_q + 8'd1;
        end else if (!arrive[gi] && depart[gi] && (queue_q != 8'h00)) begin
          queue_d = queue_q - 8'd1;
        end
      end

      always_comb begin
        if (int'(queue_q) < LVL_TH1) begin
          level_d = 2'd0;
        end else if (int'(queue_q) < LVL_TH2) begin
          level_d = 2'd1;
        end else if (int'(queue_q) < LVL_TH3) begin
          level_d = 2'd2;
        end else begin
          level_d = 2'd3;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          queue_q <= 8'd0;
          level_q <= 2'd0;
        end else begin
          queue_q <= queue_d;
          if (win_wrap) begin
            level_q <= level_d;
          end
        end
      end

      assign queue_all[gi*8 +: 8] = queue_q;
      assign level_all[gi*2 +: 2] = level_q;
    end
  endgenerate

  assign north_queue         = queue_all[7:0];
  assign south_queue         = queue_all[15:8];
  assign east_queue          = queue_all[23:16];
  assign west_queue          = queue_all[31:24];
  assign north_ml_level      = level_all[1:0];
  assign south_ml_level      = level_all[3:2];
  assign east_ml_level       = level_all[5:4];
  assign west_ml_level       = level_all[7:6];
  assign ml_prediction_valid = valid_q;

`ifdef EMERG_ARB_EN
  localparam int HOLD_CYC = EMERG_HOLD_SECONDS * ONE_SECOND;
  localparam int HOLD_W   = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } emerg_state_e;

  emerg_state_e      state_q;
  emerg_state_e      state_d;
  logic [1:0]        dir_q;
  logic [1:0]        dir_d;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;
  logic [1:0]        grant;

  // Lowest-index request wins.
  always_comb begin
    grant = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (emerg_req[i]) begin
        grant = 2'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dir_q   <= 2'd0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (|emerg_req) begin
          state_d = ST_ACTIVE;
          dir_d   = grant;
        end
      end
      ST_ACTIVE: begin
        if (!emerg_req[dir_q]) begin
          state_d = ST_HOLD;
          hold_d  = '0;
        end
      end
      ST_HOLD: begin
        if (emerg_req[dir_q]) begin
          state_d = ST_ACTIVE;
        end else if (hold_q == HOLD_W'(HOLD_CYC - 1)) begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = '0;
      end
    endcase
  end

  assign emergency_override  = (state_q != ST_IDLE);
  assign emergency_direction = dir_q;
`else
  logic unused_emerg;
  assign unused_emerg        = ^emerg_req;
  assign emergency_override  = 1'b0;
  assign emergency_direction = 2'd0;
`endif

endmodule

// File: tb/tb_traffic_sensor_aggregator.sv
// Directed bench for traffic_sensor_aggregator with a 4-cycle window and
// 4-cycle emergency hold; emergency steps follow the EMERG_ARB_EN build.
module tb_traffic_sensor_aggregator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] arrive = 4'd0;
  logic [3:0] depart = 4'd0;
  logic [3:0] emerg_req = 4'd0;
  logic [7:0] north_queue, south_queue, east_queue, west_queue;
  logic [1:0] north_ml_level, south_ml_level, east_ml_level, west_ml_level;
  logic       ml_prediction_valid;
  logic       emergency_override;
  logic [1:0] emergency_direction;

  int n_chk  = 0;
  int n_fail = 0;

  traffic_sensor_aggregator #(
    .ONE_SECOND(2), .WINDOW_SECONDS(2), .EMERG_HOLD_SECONDS(2),
    .LVL_TH1(16), .LVL_TH2(32), .LVL_TH3(64)
  ) dut (
    .clk(clk), .reset(reset), .arrive(arrive), .depart(depart),
    .emerg_req(emerg_req),
    .north_queue(north_queue), .south_queue(south_queue),
    .east_queue(east_queue), .west_queue(west_queue),
    .north_ml_level(north_ml_level), .south_ml_level(south_ml_level),
    .east_ml_level(east_ml_level), .west_ml_level(west_ml_level),
    .ml_prediction_valid(ml_prediction_valid),
    .emergency_override(emergency_override),
    .emergency_direction(emergency_direction)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic arrivals(input logic [3:0] mask, input int n);
    arrive = mask;
    repeat (n) tick();
    arrive = 4'd0;
  endtask

  task automatic departures(input logic [3:0] mask, input int n);
    depart = mask;
    repeat (n) tick();
    depart = 4'd0;
  endtask

  // Skips any pulse from the current edge, then waits for the next one.
  task automatic wait_valid();
    int n = 0;
    do begin
      tick();
      n++;
    end while (ml_prediction_valid !== 1'b1 && n < 20);
    chk("valid_seen", 32'(ml_prediction_valid), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_nq", north_queue, 0);
    chk("rst_wl", west_ml_level, 0);
    chk("rst_valid", ml_prediction_valid, 0);
    chk("rst_ovr", emergency_override, 0);
    chk("rst_dir", emergency_direction, 0);
    reset = 1'b0;

    // First valid pulse on the 4th edge after release, one cycle wide
    tick(); tick(); tick();
    chk("valid_edge3", ml_prediction_valid, 0);
    tick();
    chk("valid_edge4", ml_prediction_valid, 1);
    tick();
    chk("valid_edge5", ml_prediction_valid, 0);

    // North count up and saturating count down
    arrivals(4'b0001, 20);
    chk("n_up20", north_queue, 20);
    departures(4'b0001, 20);
    chk("n_down20", north_queue, 0);
    departures(4'b0001, 5);
    chk("n_down25", north_queue, 0);

    // West levels across thresholds
    arrivals(4'b1000, 40);
    chk("w_q40", west_queue, 40);
    wait_valid();
    chk("w_lvl40", west_ml_level, 2);
    chk("n_lvl0", north_ml_level, 0);
    chk("s_lvl0", south_ml_level, 0);
    chk("e_lvl0", east_ml_level, 0);
    tick();
    chk("valid_width", ml_prediction_valid, 0);
    chk("w_lvl_hold", west_ml_level, 2);
    arrivals(4'b1000, 23);
    wait_valid();
    chk("w_lvl63", west_ml_level, 2);
    arrivals(4'b1000, 1);
    wait_valid();
    chk("w_lvl64", west_ml_level, 3);

    // North at TH1 boundary
    arrivals(4'b0001, 16);
    wait_valid();
    chk("n_lvl16", north_ml_level, 1);
    departures(4'b0001, 1);
    wait_valid();
    chk("n_lvl15", north_ml_level, 0);

    // South simultaneous arrive/depart, east decrement at zero
    arrivals(4'b0010, 7);
    arrive = 4'b0010; depart = 4'b0010;
    tick();
    arrive = 4'd0; depart = 4'd0;
    chk("s_both", south_queue, 7);
    departures(4'b0100, 1);
    chk("e_floor", east_queue, 0);

    // East saturation at 255
    arrivals(4'b0100, 255);
    chk("e_255", east_queue, 255);
    arrivals(4'b0100, 1);
    chk("e_sat", east_queue, 255);
    arrive = 4'b0100; depart = 4'b0100;
    tick();
    arrive = 4'd0; depart = 4'd0;
    chk("e_both255", east_queue, 255);
    departures(4'b0100, 1);
    chk("e_254", east_queue, 254);

    // Independent directions in one cycle
    arrive = 4'b0001; depart = 4'b0010;
    tick();
    arrive = 4'd0; depart = 4'd0;
    chk("n_indep", north_queue, 16);
    chk("s_indep", south_queue, 6);

`ifdef EMERG_ARB_EN
    emerg_req = 4'b1100;
    chk("em_idle", emergency_override, 0);
    tick();
    chk("em_act_ovr", emergency_override, 1);
    chk("em_act_dir", emergency_direction, 2);
    emerg_req = 4'b1000;
    tick();
    chk("em_hold_ovr", emergency_override, 1);
    chk("em_hold_dir", emergency_direction, 2);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("em_hold_cnt", emergency_override, 1);
    end
    tick();
    chk("em_expire_ovr", emergency_override, 0);
    chk("em_idle_dir", emergency_direction, 2);
    tick();
    chk("em_regrant_ovr", emergency_override, 1);
    chk("em_regrant_dir", emergency_direction, 3);
    emerg_req = 4'b1001;
    tick();
    chk("em_nopreempt", emergency_direction, 3);
    // Return from HOLD to ACTIVE, then a full fresh hold period
    emerg_req = 4'b0000;
    tick(); tick(); tick();
    chk("em_hold2", emergency_override, 1);
    emerg_req = 4'b1000;
    tick();
    chk("em_reactive", emergency_override, 1);
    emerg_req = 4'b0001;
    for (int i = 0; i <= 3; i++) begin
      tick();
      chk("em_hold3", emergency_override, 1);
    end
    tick();
    chk("em_expire2", emergency_override, 0);
    tick();
    chk("em_dir_n", emergency_direction, 0);
    emerg_req = 4'b0100;
    tick(); tick();
    chk("em_dir_s_idle", emergency_override, 1);
    emerg_req = 4'b1000;
    tick();
    emerg_req = 4'b0000;
`else
    emerg_req = 4'b1111;
    tick();
    chk("em_off_ovr", emergency_override, 0);
    chk("em_off_dir", emergency_direction, 0);
    tick();
    chk("em_off_ovr2", emergency_override, 0);
    emerg_req = 4'b0000;
`endif

    // Asynchronous reset mid-operation, checked before any clock edge
    arrive = 4'b0001;
    reset = 1'b1;
    #1;
    chk("arst_nq", north_queue, 0);
    chk("arst_eq", east_queue, 0);
    chk("arst_wq", west_queue, 0);
    chk("arst_wl", west_ml_level, 0);
    chk("arst_ovr", emergency_override, 0);
    chk("arst_dir", emergency_direction, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    arrive = 4'd0;
    chk("post_rst_nq", north_queue, 1);
    chk("post_rst_sq", south_queue, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
